// File: rtl/mii_frame_scheduler.sv
// Round-robin frame scheduler sharing one XGMII frame generator among N_REQ sources.
// Define MII_SCHED_STRICT_PRIO_EN for fixed lowest-index-wins priority.
module mii_frame_scheduler #(
    parameter int N_REQ            = 4,
    parameter int PAYLOAD_MAX_SIZE = 1500,
    parameter int IPG_CYCLES       = 2,
    parameter int START_TIMEOUT    = 16
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [16*N_REQ-1:0]      i_req_len,
    input  logic [8*N_REQ-1:0]       i_req_mode,
    input  logic                     i_gen_valid,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_gen_start,
    output logic [15:0]              o_gen_len,
    output logic [7:0]               o_gen_mode,
    output logic [$clog2(N_REQ)-1:0] o_gen_sel,
    output logic                     o_busy,
    output logic                     o_drop,
    output logic                     o_err_timeout,
    output logic [15:0]              o_frame_cnt,
    output logic [7:0]               o_drop_cnt
);

    localparam int SW = $clog2(N_REQ);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ACTIVE, GAP} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   rr_ptr, rr_ptr_n;
    logic [15:0]     cnt, cnt_n;

    logic [N_REQ-1:0] grant_n;
    logic             start_n, drop_n, err_n;
    logic [15:0]      len_n, frame_n;
    logic [7:0]       mode_n, drop_cnt_n;
    logic [SW-1:0]    sel_n;

    logic             found;
    logic [SW-1:0]    win;
    logic [15:0]      win_len;
    logic [7:0]       win_mode;
    logic             len_bad;

    always_comb begin
        logic [SW:0]   jj;
        logic [SW-1:0] idx;
        found = 1'b0;
        win   = '0;
        jj    = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef MII_SCHED_STRICT_PRIO_EN
            idx = SW'(i);
`else
            jj = {1'b0, rr_ptr} + (SW+1)'(i);
            if (jj >= (SW+1)'(N_REQ))
                jj = jj - (SW+1)'(N_REQ);
            idx = jj[SW-1:0];
`endif
            if (!found && i_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_len  = i_req_len[{win, 4'b0000} +: 16];
    assign win_mode = i_req_mode[{win, 3'b000} +: 8];
    assign len_bad  = (win_len == 16'd0) ||
                      (win_len > 16'(PAYLOAD_MAX_SIZE));

    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        cnt_n      = cnt;
        grant_n    = '0;
        start_n    = 1'b0;
        drop_n     = 1'b0;
        err_n      = o_err_timeout;
        len_n      = o_gen_len;
        mode_n     = o_gen_mode;
        sel_n      = o_gen_sel;
        frame_n    = o_frame_cnt;
        drop_cnt_n = o_drop_cnt;
        unique case (state)
            IDLE: begin
                if (i_enable && found) begin
                    grant_n[win] = 1'b1;
`ifndef MII_SCHED_STRICT_PRIO_EN
                    rr_ptr_n = (win == SW'(N_REQ-1)) ? '0 : win + 1'b1;
`endif
                    if (len_bad) begin
                        drop_n = 1'b1;
                        if (o_drop_cnt != 8'hFF)
                            drop_cnt_n = o_drop_cnt + 8'd1;
                    end else begin
                        len_n   = win_len;
                        mode_n  = win_mode;
                        sel_n   = win;
                        start_n = 1'b1;
                        state_n = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // timeout edge lands START_TIMEOUT+1 cycles after the start pulse
                if (i_gen_valid) begin
                    state_n = ACTIVE;
                end else if (cnt + 16'd1 >= 16'(START_TIMEOUT)) begin
                    err_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            ACTIVE: begin
                if (!i_gen_valid) begin
                    frame_n = o_frame_cnt + 16'd1;
                    cnt_n   = '0;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (cnt + 16'd1 >= 16'(IPG_CYCLES)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            o_grant       <= '0;
            o_gen_start   <= 1'b0;
            o_gen_len     <= '0;
            o_gen_mode    <= '0;
            o_gen_sel     <= '0;
            o_busy        <= 1'b0;
            o_drop        <= 1'b0;
            o_err_timeout <= 1'b0;
            o_frame_cnt   <= '0;
            o_drop_cnt    <= '0;
        end else begin
            state         <= state_n;
            rr_ptr        <= rr_ptr_n;
            cnt           <= cnt_n;
            o_grant       <= grant_n;
            o_gen_start   <= start_n;
            o_gen_len     <= len_n;
            o_gen_mode    <= mode_n;
            o_gen_sel     <= sel_n;
            o_busy        <= (state_n != IDLE);
            o_drop        <= drop_n;
            o_err_timeout <= err_n;
            o_frame_cnt   <= frame_n;
            o_drop_cnt    <= drop_cnt_n;
        end
    end

endmodule

// File: tb/tb_mii_frame_scheduler.sv
// Directed bench for mii_frame_scheduler: grants, drops, timeout, reset, gating.
// Honours MII_SCHED_STRICT_PRIO_EN for the all-sources grant order.
module tb_mii_frame_scheduler;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_enable;
    logic [3:0]  i_req;
    logic [63:0] i_req_len;
    logic [31:0] i_req_mode;
    logic        i_gen_valid;
    logic [3:0]  o_grant;
    logic        o_gen_start;
    logic [15:0] o_gen_len;
    logic [7:0]  o_gen_mode;
    logic [1:0]  o_gen_sel;
    logic        o_busy;
    logic        o_drop;
    logic        o_err_timeout;
    logic [15:0] o_frame_cnt;
    logic [7:0]  o_drop_cnt;

    int n_err = 0;
    int n_checks = 0;

    mii_frame_scheduler dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .i_req        (i_req),
        .i_req_len    (i_req_len),
        .i_req_mode   (i_req_mode),
        .i_gen_valid  (i_gen_valid),
        .o_grant      (o_grant),
        .o_gen_start  (o_gen_start),
        .o_gen_len    (o_gen_len),
        .o_gen_mode   (o_gen_mode),
        .o_gen_sel    (o_gen_sel),
        .o_busy       (o_busy),
        .o_drop       (o_drop),
        .o_err_timeout(o_err_timeout),
        .o_frame_cnt  (o_frame_cnt),
        .o_drop_cnt   (o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output int k);
        k = 0;
        while (o_grant == 4'b0000 && k < 40) begin
            tick(1);
            k++;
        end
    endtask

    task automatic do_frame(input int nv);
        tick(1);
        i_gen_valid = 1'b1;
        tick(nv);
        i_gen_valid = 1'b0;
        tick(1);
    endtask

    int         exp_idx[5];
    logic [3:0] one;
    int         k;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef MII_SCHED_STRICT_PRIO_EN
        exp_idx = '{0, 0, 0, 0, 0};
`else
        exp_idx = '{0, 1, 2, 3, 0};
`endif
        i_rst_n     = 1'b0;
        i_enable    = 1'b0;
        i_req       = '0;
        i_req_len   = '0;
        i_req_mode  = '0;
        i_gen_valid = 1'b0;
        tick(2);
        chk("rst_grant", o_grant, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_frame_cnt", o_frame_cnt, 0);
        chk("rst_drop_cnt", o_drop_cnt, 0);
        chk("rst_err", o_err_timeout, 0);
        chk("rst_gen_len", o_gen_len, 0);

        // single frame from source 0
        i_rst_n = 1'b1;
        i_enable = 1'b1;
        i_req_len[15:0] = 16'd46;
        i_req = 4'b0001;
        tick(1);
        chk("sf_grant", o_grant, 4'b0001);
        chk("sf_start", o_gen_start, 1);
        chk("sf_len", o_gen_len, 46);
        chk("sf_sel", o_gen_sel, 0);
        chk("sf_busy", o_busy, 1);
        i_req = 4'b0000;
        tick(1);
        chk("sf_start_pulse", o_gen_start, 0);
        chk("sf_grant_pulse", o_grant, 0);
        i_gen_valid = 1'b1;
        tick(9);
        i_gen_valid = 1'b0;
        tick(1);
        chk("sf_frame_cnt", o_frame_cnt, 1);
        tick(1);
        chk("sf_busy_gap", o_busy, 1);
        tick(1);
        chk("sf_busy_drop", o_busy, 0);

        // back-to-back invalid lengths
        i_req_len[31:16] = 16'd0;
        i_req = 4'b0010;
        tick(1);
        chk("drop1_grant", o_grant, 4'b0010);
        chk("drop1_pulse", o_drop, 1);
        chk("drop1_cnt", o_drop_cnt, 1);
        chk("drop1_start", o_gen_start, 0);
        i_req_len[47:32] = 16'd1501;
        i_req = 4'b0100;
        tick(1);
        chk("drop2_grant", o_grant, 4'b0100);
        chk("drop2_pulse", o_drop, 1);
        chk("drop2_cnt", o_drop_cnt, 2);
        chk("drop2_start", o_gen_start, 0);
        chk("drop2_len", o_gen_len, 46);
        chk("drop2_busy", o_busy, 0);
        i_req = 4'b0000;
        tick(1);
        chk("drop_end", o_drop, 0);

        // start timeout on source 3
        i_req_len[63:48] = 16'd64;
        i_req_mode[31:24] = 8'h5A;
        i_req = 4'b1000;
        tick(1);
        chk("to_grant", o_grant, 4'b1000);
        chk("to_start", o_gen_start, 1);
        chk("to_mode", o_gen_mode, 8'h5A);
        chk("to_sel", o_gen_sel, 3);
        i_req = 4'b0000;
        tick(16);
        chk("to_err_early", o_err_timeout, 0);
        tick(1);
        chk("to_err_rise", o_err_timeout, 1);
        tick(2);
        chk("to_idle", o_busy, 0);
        chk("to_frame_cnt", o_frame_cnt, 1);

        i_req_len[15:0] = 16'd100;
        i_req_mode[7:0] = 8'h03;
        i_req = 4'b0001;
        tick(1);
        chk("post_to_grant", o_grant, 4'b0001);
        chk("post_to_len", o_gen_len, 100);
        i_req = 4'b0000;
        do_frame(4);
        chk("post_to_frame_cnt", o_frame_cnt, 2);
        chk("err_sticky", o_err_timeout, 1);
        tick(2);

        // enable gating
        i_enable = 1'b0;
        i_req_len[47:32] = 16'd200;
        i_req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("gate_no_grant", o_grant, 0);
        end
        i_enable = 1'b1;
        tick(1);
        chk("gate_grant", o_grant, 4'b0100);
        chk("gate_len", o_gen_len, 200);
        i_req = 4'b0000;

        // reset while ACTIVE
        tick(1);
        i_gen_valid = 1'b1;
        tick(3);
        chk("mid_busy", o_busy, 1);
        i_rst_n = 1'b0;
        tick(1);
        chk("mr_busy", o_busy, 0);
        chk("mr_frame_cnt", o_frame_cnt, 0);
        chk("mr_drop_cnt", o_drop_cnt, 0);
        chk("mr_err", o_err_timeout, 0);
        chk("mr_len", o_gen_len, 0);
        chk("mr_mode", o_gen_mode, 0);
        chk("mr_sel", o_gen_sel, 0);
        chk("mr_start", o_gen_start, 0);
        i_rst_n = 1'b1;
        i_gen_valid = 1'b0;

        // all sources requesting for five frames
        for (int s = 0; s < 4; s++) begin
            i_req_len[16*s +: 16] = 16'(60 + s);
            i_req_mode[8*s +: 8] = 8'(s);
        end
        i_req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_grant(k);
            one = 4'b0001 << exp_idx[f];
            chk("rr_grant", o_grant, one);
            chk("rr_sel", o_gen_sel, exp_idx[f]);
            chk("rr_len", o_gen_len, 60 + exp_idx[f]);
            if (f == 0)
                chk("rr_first_lat", k, 1);
            else
                chk("rr_ipg_lat", k, 3);
            do_frame(3);
            chk("rr_frame_cnt", o_frame_cnt, f + 1);
        end
        i_req = 4'b0000;
        tick(3);
        chk("final_idle", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
